// File: rtl/noc_pkt_tx.sv
// noc_pkt_tx: packet injector that drives the write side of a NoC input FIFO.
// A packet is one head flit followed by PKTLEN body flits, and the last body
// flit is tagged as the tail. A packet starts only when ordy shows room for
// the whole packet, so an accepted packet never waits on backpressure.
// Optional build macro NOC_TX_STALL_CNT_EN adds a saturating counter of
// payload-starved BODY cycles on stall_cnt. Without it, stall_cnt is tied to 0.
module noc_pkt_tx #(
  parameter int DATAW  = 33,
  parameter int PKTLEN = 4,
  parameter int DSTW   = 4,
  parameter int SRC_ID = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_req,
  input  logic [DSTW-1:0]   pkt_dst,
  output logic              pkt_ack,
  input  logic [DATAW-2:0]  pld_data,
  input  logic              pld_valid,
  output logic              pld_rd,
  output logic [DATAW:0]    odata,
  output logic              wr_en,
  input  logic              ordy,
  output logic              busy,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       stall_cnt
);

  localparam int FW = DATAW + 1;
  localparam int PW = DATAW - 1;
  localparam int BW = (PKTLEN > 1) ? $clog2(PKTLEN) : 1;

  localparam logic [1:0]      T_HEAD = 2'b01;
  localparam logic [1:0]      T_BODY = 2'b00;
  localparam logic [1:0]      T_TAIL = 2'b10;
  localparam logic [DSTW-1:0] SRC    = DSTW'(SRC_ID);
  localparam logic [BW-1:0]   LAST   = BW'(PKTLEN - 1);

  typedef enum logic [1:0] {IDLE, BODY, GAP} state_t;

  state_t        state;
  logic [BW-1:0] beat;
  logic          last_beat;

  // Head flit: destination in the low field, this node's id above it.
  function automatic logic [FW-1:0] head_flit(input logic [DSTW-1:0] dst);
    logic [PW-1:0] pl;
    pl = '0;
    pl[DSTW-1:0]      = dst;
    pl[2*DSTW-1:DSTW] = SRC;
    return {T_HEAD, pl};
  endfunction

  assign last_beat = (beat == LAST);

  // Payload is consumed only while streaming body flits.
  assign pld_rd = (state == BODY) && pld_valid;
  assign busy   = (state != IDLE);

  // Packet sequencer. Flit and strobe outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      odata   <= '0;
      wr_en   <= 1'b0;
      pkt_ack <= 1'b0;
      beat    <= '0;
      pkt_cnt <= '0;
    end else begin
      wr_en   <= 1'b0;
      pkt_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (pkt_req && ordy) begin
            odata   <= head_flit(pkt_dst);
            wr_en   <= 1'b1;
            pkt_ack <= 1'b1;
            beat    <= '0;
            state   <= BODY;
          end
        end
        BODY: begin
          if (pld_valid) begin
            odata <= {(last_beat ? T_TAIL : T_BODY), pld_data};
            wr_en <= 1'b1;
            beat  <= beat + 1'b1;
            if (last_beat) begin
              pkt_cnt <= pkt_cnt + 16'd1;
              state   <= GAP;
            end
          end
        end
        // The GAP cycle lets ordy see the tail before the next head.
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NOC_TX_STALL_CNT_EN
  logic [15:0] stall_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Count BODY cycles that are starved of payload, saturating at the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((state == BODY) && !pld_valid) begin
      stall_q <= sat_inc(stall_q);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/noc_pkt_tx.md
Name: noc_pkt_tx

Overview:
Packet injector on the write side of a NoC input FIFO. It accepts a packet request and streams PKTLEN+1 flits into the downstream FIFO: one head flit, then PKTLEN body flits, the last of which is the tail. A packet starts only when the FIFO's ordy indicates room for a whole packet, so once started the packet never stalls on backpressure. It sits in the network interface or router output stage, driving the FIFO's idata and wr_en.

Parameters:
DATAW, 33, flit MSB index; flit = DATAW+1 bits = 2-bit type [DATAW:DATAW-1] + payload [DATAW-2:0]
PKTLEN, 4, body flits per packet including tail; packet = PKTLEN+1 flits; legal range >= 1
DSTW, 4, destination/source id width; 2*DSTW <= DATAW-1
SRC_ID, 0, this node's id, placed in the head flit

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
pkt_req  in  1  packet request; held high until pkt_ack
pkt_dst  in  DSTW  destination id; sampled on the accept cycle
pkt_ack  out  1  one-cycle pulse, coincident with head-flit wr_en
pld_data  in  DATAW-1  payload for the current body/tail flit
pld_valid  in  1  pld_data valid
pld_rd  out  1  payload consumed this cycle (combinational)
odata  out  DATAW+1  flit to FIFO idata (registered)
wr_en  out  1  FIFO write strobe (registered)
ordy  in  1  FIFO has space for PKTLEN+1 flits
busy  out  1  state != IDLE
pkt_cnt  out  16  packets launched, wraps at 0xFFFF->0
stall_cnt  out  16  see Optional Feature

Behaviour:
- Async reset: state=IDLE, odata=0, wr_en=0, pkt_ack=0, beat count=0, pkt_cnt=0, stall_cnt=0. Reset mid-packet truncates the packet; no flits follow.
- Flit types: 01 head, 00 body, 10 tail. Type 11 is never emitted.
- Head payload: [DSTW-1:0]=pkt_dst, [2*DSTW-1:DSTW]=SRC_ID, upper bits 0. Body/tail payload = pld_data.
- IDLE: if pkt_req & ordy -> at the edge: odata<=head, wr_en<=1, pkt_ack<=1, beat<=0, state<=BODY. Otherwise wr_en<=0. ordy low blocks start indefinitely.
- BODY: pld_rd = pld_valid.
  - If pld_valid: odata<=flit, wr_en<=1, beat<=beat+1.
  - When beat==PKTLEN-1, the flit is tagged tail, pkt_cnt<=pkt_cnt+1, state<=GAP.
  - If ~pld_valid: wr_en<=0 (bubble); state and beat hold.
- GAP: one cycle. The tail's wr_en is visible this cycle. wr_en<=0, state<=IDLE. This guarantees ordy reflects the tail before the next start. Minimum head-to-head spacing = PKTLEN+2 cycles.
- Latency: accept edge -> head on odata/wr_en the next cycle. pld_rd cycle -> flit on wr_en the next cycle.
- pkt_req is ignored outside IDLE. The pkt_dst value is held in the head register.
- The block never writes more than PKTLEN+1 flits per accepted ordy, and it has no full input.

Optional Feature:
Macro NOC_TX_STALL_CNT_EN.
- Defined: stall_cnt counts BODY cycles with pld_valid=0, saturating at 0xFFFF, cleared only by reset.
- Undefined: stall_cnt is tied to 0 and no counter logic is built.
- The port is present in both builds.

Test Plan:
- Assert rst mid-cycle with no clock -> all outputs 0 immediately; pkt_cnt=0.
- PKTLEN=4, SRC_ID=2, ordy=1, pld_valid=1 (data 0xA0..0xA3), pkt_req with dst=5 -> next cycle wr_en=1 with head odata type 01 and payload 0x25, plus pkt_ack pulse. Then 4 consecutive flits: types 00,00,00,10 with payloads 0xA0..0xA3. Then busy=0 and pkt_cnt=1.
- pkt_req=1, ordy=0 for 10 cycles -> wr_en=0, pkt_ack=0 throughout. Raise ordy -> head appears exactly 1 cycle later.
- Drop pld_valid for 3 cycles after the 2nd body flit -> wr_en low for exactly 3 cycles, flit order and tail type preserved. stall_cnt=3 with NOC_TX_STALL_CNT_EN, 0 without.
- pkt_req held high continuously with ordy=1 -> heads spaced exactly PKTLEN+2=6 cycles apart. After 0x10000 packets, pkt_cnt wraps to 0.
- Assert rst after the 2nd body flit, release, issue a new request -> no residual flits; the new packet starts with a head flit and pkt_cnt counts from 0.
